// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-ported 32-bit word memory.
// Each grant drives the memory combinationally in its grant cycle. The completion
// pulse comes back to the requester one cycle later.
// Optional feature: define MEM_ARBITER_RR_EN for round-robin conflict resolution.
// Without it, port 0 has fixed priority.
module mem_arbiter #(
    parameter int unsigned N = 9
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_req0_valid,
    output logic         o_req0_ready,
    input  logic         i_req0_wren,
    input  logic [3:0]   i_req0_bmask,
    input  logic [N-1:0] i_req0_addr,
    input  logic [31:0]  i_req0_wdata,
    output logic         o_rsp0_valid,
    output logic [31:0]  o_rsp0_rdata,
    input  logic         i_req1_valid,
    output logic         o_req1_ready,
    input  logic         i_req1_wren,
    input  logic [3:0]   i_req1_bmask,
    input  logic [N-1:0] i_req1_addr,
    input  logic [31:0]  i_req1_wdata,
    output logic         o_rsp1_valid,
    output logic [31:0]  o_rsp1_rdata,
    output logic         o_mem_wren,
    output logic [3:0]   o_mem_bmask,
    output logic [N-1:0] o_mem_addr,
    output logic [31:0]  o_mem_wdata,
    input  logic [31:0]  i_mem_rdata
);

    logic        gnt0, gnt1;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q, rsp_id_d;
    logic        rsp_wren_q, rsp_wren_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic [31:0] hold0_q, hold0_d;
    logic [31:0] hold1_q, hold1_d;
    logic        rsp_live;
    logic [31:0] rsp_data;

`ifdef MEM_ARBITER_RR_EN
    // ptr_q holds the last-granted port. A reset value of 1 lets port 0 win the first conflict.
    logic ptr_q, ptr_d;

    // Round-robin grant: on a conflict, the port that was not granted last wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (i_reset) begin
            if (i_req0_valid && i_req1_valid) begin
                gnt0 = ptr_q;
                gnt1 = ~ptr_q;
            end else begin
                gnt0 = i_req0_valid;
                gnt1 = i_req1_valid;
            end
        end
    end

    // The pointer moves only when a grant is issued.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt0) begin
            ptr_d = 1'b0;
        end else if (gnt1) begin
            ptr_d = 1'b1;
        end
    end

    // Last-granted pointer register.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            ptr_q <= 1'b1;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed-priority grant: port 0 always wins a conflict.
    always_comb begin
        gnt0 = i_reset & i_req0_valid;
        gnt1 = i_reset & i_req1_valid & ~i_req0_valid;
    end
`endif

    assign o_req0_ready = gnt0;
    assign o_req1_ready = gnt1;

    // Steer the granted request onto the memory bus. The bus is all zeros when idle.
    always_comb begin
        o_mem_wren  = 1'b0;
        o_mem_bmask = 4'b0000;
        o_mem_addr  = '0;
        o_mem_wdata = 32'h0;
        if (gnt0) begin
            o_mem_wren  = i_req0_wren;
            o_mem_bmask = i_req0_bmask;
            o_mem_addr  = i_req0_addr;
            o_mem_wdata = i_req0_wdata;
        end else if (gnt1) begin
            o_mem_wren  = i_req1_wren;
            o_mem_bmask = i_req1_bmask;
            o_mem_addr  = i_req1_addr;
            o_mem_wdata = i_req1_wdata;
        end
    end

    // Response outputs. A pending response is suppressed while reset is asserted.
    always_comb begin
        rsp_live     = rsp_valid_q & i_reset;
        rsp_data     = rsp_wren_q ? 32'h0 : rsp_rdata_q;
        o_rsp0_valid = rsp_live & ~rsp_id_q;
        o_rsp1_valid = rsp_live & rsp_id_q;
        o_rsp0_rdata = o_rsp0_valid ? rsp_data : hold0_q;
        o_rsp1_rdata = o_rsp1_valid ? rsp_data : hold1_q;
    end

    // Capture the grant for next cycle's response. Per-port read data is held between responses.
    always_comb begin
        rsp_valid_d = gnt0 | gnt1;
        rsp_id_d    = gnt1;
        rsp_wren_d  = o_mem_wren;
        rsp_rdata_d = (rsp_valid_d && !o_mem_wren) ? i_mem_rdata : 32'h0;
        hold0_d     = o_rsp0_rdata;
        hold1_d     = o_rsp1_rdata;
    end

    // Response and hold registers.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_wren_q  <= 1'b0;
            rsp_rdata_q <= 32'h0;
            hold0_q     <= 32'h0;
            hold1_q     <= 32'h0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_wren_q  <= rsp_wren_d;
            rsp_rdata_q <= rsp_rdata_d;
            hold0_q     <= hold0_d;
            hold1_q     <= hold1_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter. It pairs a byte-lane memory model on the bus with a
// transaction-level reference model. The reference predicts grants, bus contents
// and responses.
module tb_mem_arbiter;

    localparam int unsigned N = 9;
`ifdef MEM_ARBITER_RR_EN
    localparam bit RoundRobin = 1'b1;
`else
    localparam bit RoundRobin = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         rv [2];
    logic         rw [2];
    logic [3:0]   rb [2];
    logic [N-1:0] ra [2];
    logic [31:0]  rd [2];

    logic         ready0, ready1, rsp0_valid, rsp1_valid;
    logic [31:0]  rsp0_rdata, rsp1_rdata;
    logic         mem_wren;
    logic [3:0]   mem_bmask;
    logic [N-1:0] mem_addr;
    logic [31:0]  mem_wdata, mem_rdata;

    logic [31:0]  tb_mem [512] = '{default: 32'h0};
    logic [31:0]  ref_mem [512];
    logic [31:0]  exp_rd [2];
    logic [1:0]   exp_rv;
    int           last_g;
    int           model_g;
    int           dut_g;
    int           gseq [4];
    int           total;
    int           bad;

    mem_arbiter #(.N(N)) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_req0_valid (rv[0]),
        .o_req0_ready (ready0),
        .i_req0_wren  (rw[0]),
        .i_req0_bmask (rb[0]),
        .i_req0_addr  (ra[0]),
        .i_req0_wdata (rd[0]),
        .o_rsp0_valid (rsp0_valid),
        .o_rsp0_rdata (rsp0_rdata),
        .i_req1_valid (rv[1]),
        .o_req1_ready (ready1),
        .i_req1_wren  (rw[1]),
        .i_req1_bmask (rb[1]),
        .i_req1_addr  (ra[1]),
        .i_req1_wdata (rd[1]),
        .o_rsp1_valid (rsp1_valid),
        .o_rsp1_rdata (rsp1_rdata),
        .o_mem_wren   (mem_wren),
        .o_mem_bmask  (mem_bmask),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory on the bus: combinational read, byte-lane write on the clock edge.
    assign mem_rdata = tb_mem[mem_addr];
    always @(posedge clk) begin
        if (mem_wren) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_bmask[b]) tb_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int k, input logic v, input logic w, input logic [3:0] m,
                           input logic [N-1:0] a, input logic [31:0] d);
        rv[k] = v;
        rw[k] = w;
        rb[k] = m;
        ra[k] = a;
        rd[k] = d;
    endtask

    // One clock cycle. Inputs are already driven. Check the previous cycle's responses
    // and this cycle's grant/bus, then advance the model and the clock.
    task automatic do_cycle();
        logic [31:0] rdat;
        #1;
        chk("rsp0_valid", rsp0_valid, 32'(exp_rv[0] & rst_n));
        chk("rsp1_valid", rsp1_valid, 32'(exp_rv[1] & rst_n));
        if (rst_n) begin
            chk("rsp0_rdata", rsp0_rdata, exp_rd[0]);
            chk("rsp1_rdata", rsp1_rdata, exp_rd[1]);
        end
        if (!rst_n) model_g = -1;
        else if (rv[0] && rv[1]) model_g = RoundRobin ? (last_g == 0 ? 1 : 0) : 0;
        else if (rv[0]) model_g = 0;
        else if (rv[1]) model_g = 1;
        else model_g = -1;
        dut_g = ready0 ? 0 : (ready1 ? 1 : -1);
        chk("req0_ready", ready0, 32'(model_g == 0));
        chk("req1_ready", ready1, 32'(model_g == 1));
        if (model_g >= 0) begin
            chk("mem_wren", mem_wren, 32'(rw[model_g]));
            chk("mem_bmask", mem_bmask, 32'(rb[model_g]));
            chk("mem_addr", mem_addr, 32'(ra[model_g]));
            chk("mem_wdata", mem_wdata, rd[model_g]);
        end else begin
            chk("idle_mem_wren", mem_wren, 32'h0);
            chk("idle_mem_bus", {mem_bmask, 19'h0, mem_addr}, 32'h0);
            chk("idle_mem_wdata", mem_wdata, 32'h0);
        end
        if (!rst_n) begin
            exp_rv = 2'b00;
            exp_rd[0] = 32'h0;
            exp_rd[1] = 32'h0;
            last_g = 1;
        end else begin
            exp_rv = {model_g == 1, model_g == 0};
            if (model_g >= 0) begin
                rdat = rw[model_g] ? 32'h0 : ref_mem[ra[model_g]];
                exp_rd[model_g] = rdat;
                if (rw[model_g]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (rb[model_g][b]) ref_mem[ra[model_g]][8*b +: 8] = rd[model_g][8*b +: 8];
                    end
                end
                last_g = model_g;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad = 0;
        last_g = 1;
        exp_rv = 2'b00;
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
        for (int i = 0; i < 512; i++) ref_mem[i] = 32'h0;
        set_req(0, 1'b0, 1'b0, 4'h0, 9'h0, 32'h0);
        set_req(1, 1'b1, 1'b1, 4'hF, 9'h5, 32'h12345678);
        rst_n = 1'b0;

        // Reset: no grants even with a valid request, outputs cleared.
        do_cycle();
        do_cycle();
        chk("rst_rsp0_rdata", rsp0_rdata, 32'h0);
        chk("rst_rsp1_rdata", rsp1_rdata, 32'h0);
        set_req(1, 1'b0, 1'b0, 4'h0, 9'h0, 32'h0);
        rst_n = 1'b1;

        // Port 0 write then read back.
        set_req(0, 1'b1, 1'b1, 4'hF, 9'h010, 32'hDEADBEEF);
        do_cycle();
        chk("s1_wr_rsp_valid", rsp0_valid, 32'h1);
        chk("s1_wr_rsp_rdata", rsp0_rdata, 32'h0);
        set_req(0, 1'b1, 1'b0, 4'hF, 9'h010, 32'h0);
        do_cycle();
        chk("s1_rd_rsp_valid", rsp0_valid, 32'h1);
        chk("s1_rd_rdata", rsp0_rdata, 32'hDEADBEEF);
        set_req(0, 1'b0, 1'b0, 4'h0, 9'h0, 32'h0);
        do_cycle();
        chk("s1_pulse_one_cycle", rsp0_valid, 32'h0);
        chk("s1_rdata_held", rsp0_rdata, 32'hDEADBEEF);

        // Port 1 partial-lane write merges with earlier contents.
        set_req(1, 1'b1, 1'b1, 4'hF, 9'h020, 32'h11223344);
        do_cycle();
        set_req(1, 1'b1, 1'b1, 4'b0001, 9'h020, 32'h000000AB);
        do_cycle();
        set_req(1, 1'b1, 1'b0, 4'hF, 9'h020, 32'h0);
        do_cycle();
        chk("s2_rsp_valid", rsp1_valid, 32'h1);
        chk("s2_merged", rsp1_rdata, 32'h112233AB);
        set_req(1, 1'b0, 1'b0, 4'h0, 9'h0, 32'h0);

        // Conflict held for four cycles.
        set_req(0, 1'b1, 1'b0, 4'hF, 9'h010, 32'h0);
        set_req(1, 1'b1, 1'b0, 4'hF, 9'h020, 32'h0);
        for (int i = 0; i < 4; i++) begin
            do_cycle();
            gseq[i] = dut_g;
        end
        for (int i = 0; i < 4; i++) begin
            chk("s3_grant_seq", 32'(gseq[i]), RoundRobin ? 32'(i % 2) : 32'h0);
        end
        set_req(0, 1'b0, 1'b0, 4'h0, 9'h0, 32'h0);
        do_cycle();
        chk("s3_p1_served", 32'(dut_g), 32'h1);
        set_req(1, 1'b0, 1'b0, 4'h0, 9'h0, 32'h0);

        // Back-to-back reads at the address extremes.
        set_req(1, 1'b1, 1'b1, 4'hF, 9'h1FF, 32'hA5A50001);
        do_cycle();
        set_req(1, 1'b1, 1'b1, 4'hF, 9'h000, 32'h5A5A0002);
        do_cycle();
        set_req(1, 1'b0, 1'b0, 4'h0, 9'h0, 32'h0);
        set_req(0, 1'b1, 1'b0, 4'hF, 9'h1FF, 32'h0);
        do_cycle();
        chk("s4_rsp_a_valid", rsp0_valid, 32'h1);
        chk("s4_rsp_a_data", rsp0_rdata, 32'hA5A50001);
        set_req(0, 1'b1, 1'b0, 4'hF, 9'h000, 32'h0);
        do_cycle();
        chk("s4_rsp_b_valid", rsp0_valid, 32'h1);
        chk("s4_rsp_b_data", rsp0_rdata, 32'h5A5A0002);
        set_req(0, 1'b0, 1'b0, 4'h0, 9'h0, 32'h0);

        // Reset right after a read grant drops the pending response.
        set_req(0, 1'b1, 1'b0, 4'hF, 9'h010, 32'h0);
        do_cycle();
        set_req(0, 1'b1, 1'b0, 4'hF, 9'h010, 32'h0);
        rst_n = 1'b0;
        do_cycle();
        rst_n = 1'b1;
        chk("s5_no_pulse", rsp0_valid, 32'h0);
        chk("s5_rdata_cleared", rsp0_rdata, 32'h0);
        set_req(1, 1'b1, 1'b0, 4'hF, 9'h020, 32'h0);
        do_cycle();
        chk("s5_first_grant", 32'(dut_g), 32'h0);
        set_req(0, 1'b0, 1'b0, 4'h0, 9'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 4'h0, 9'h0, 32'h0);
        do_cycle();

        // A write with no byte lanes is acknowledged and leaves memory untouched.
        set_req(0, 1'b1, 1'b1, 4'b0000, 9'h010, 32'hFFFFFFFF);
        do_cycle();
        chk("s6_ack", rsp0_valid, 32'h1);
        set_req(0, 1'b1, 1'b0, 4'hF, 9'h010, 32'h0);
        do_cycle();
        chk("s6_unchanged", rsp0_rdata, 32'hDEADBEEF);
        set_req(0, 1'b0, 1'b0, 4'h0, 9'h0, 32'h0);

        // Random traffic. Requesters hold until granted, with occasional drops and resets.
        for (int c = 0; c < 400; c++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            for (int k = 0; k < 2; k++) begin
                if (!rv[k]) begin
                    if ($urandom_range(0, 3) != 0) begin
                        set_req(k, 1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                                9'($urandom_range(0, 15)), $urandom);
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    rv[k] = 1'b0;
                end
            end
            do_cycle();
            if (model_g >= 0) rv[model_g] = 1'b0;
        end
        set_req(0, 1'b0, 1'b0, 4'h0, 9'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 4'h0, 9'h0, 32'h0);
        rst_n = 1'b1;
        do_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
